// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of the ALU: decodes RV32I, builds immediates and
// operands, and holds the result in a single-entry valid/ready ID/EX register.

package alu_issue_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SLT  = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_SLTU = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SRL  = 4'b1001,
    ALU_SRA  = 4'b1010
  } alu_op_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ID/EX register payload
  typedef struct packed {
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    alu_op_e         alu_ctrl;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] pc;
    logic [2:0]      funct3;
    logic            illegal;
  } id_ex_t;

endpackage

module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_rs1_data,
  input  logic [WIDTH-1:0] in_rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] out_rs2_data,
  output logic [WIDTH-1:0] out_pc,
  output logic [2:0]       out_funct3,
  output logic             out_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic [WIDTH-1:0] imm_i;
  logic [WIDTH-1:0] imm_s;
  logic [WIDTH-1:0] imm_u;
  logic [WIDTH-1:0] imm_j;
  logic [WIDTH-1:0] imm_sh;

  logic [WIDTH-1:0] dec_a;
  logic [WIDTH-1:0] dec_b;
  alu_op_e          dec_ctrl;
  logic             dec_illegal;

  id_ex_t payload_d, payload_q;
  logic   out_valid_d, out_valid_q;
  logic   load;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // Immediate formats, sign-extended from instr[31]
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_sh = {27'b0, in_instr[24:20]};

  // Opcode/funct decode to ALU control and operand selection
  always_comb begin
    dec_a       = '0;
    dec_b       = '0;
    dec_ctrl    = ALU_ADD;
    dec_illegal = 1'b0;

    case (opcode)
      OPC_OP: begin
        dec_a = in_rs1_data;
        dec_b = in_rs2_data;
        case (funct3)
          3'b000:  dec_ctrl = ALU_ADD;
          3'b001:  dec_ctrl = ALU_SLL;
          3'b010:  dec_ctrl = ALU_SLT;
          3'b011:  dec_ctrl = ALU_SLTU;
          3'b100:  dec_ctrl = ALU_XOR;
          3'b101:  dec_ctrl = ALU_SRL;
          3'b110:  dec_ctrl = ALU_OR;
          default: dec_ctrl = ALU_AND;
        endcase
        if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      dec_ctrl = ALU_SUB;
          else if (funct3 == 3'b101) dec_ctrl = ALU_SRA;
          else                       dec_illegal = 1'b1;
        end else if (funct7 != F7_BASE) begin
          dec_illegal = 1'b1;
        end
      end

      OPC_OP_IMM: begin
        dec_a = in_rs1_data;
        dec_b = imm_i;
        case (funct3)
          3'b000: dec_ctrl = ALU_ADD;
          3'b001: begin
            dec_ctrl = ALU_SLL;
            dec_b    = imm_sh;
            if (funct7 != F7_BASE) dec_illegal = 1'b1;
          end
          3'b010: dec_ctrl = ALU_SLT;
          3'b011: dec_ctrl = ALU_SLTU;
          3'b100: dec_ctrl = ALU_XOR;
          3'b101: begin
            dec_b = imm_sh;
            if (funct7 == F7_BASE)     dec_ctrl = ALU_SRL;
            else if (funct7 == F7_ALT) dec_ctrl = ALU_SRA;
            else                       dec_illegal = 1'b1;
          end
          3'b110:  dec_ctrl = ALU_OR;
          default: dec_ctrl = ALU_AND;
        endcase
      end

      OPC_LOAD, OPC_JALR: begin
        dec_a = in_rs1_data;
        dec_b = imm_i;
      end

      OPC_STORE: begin
        dec_a = in_rs1_data;
        dec_b = imm_s;
      end

      OPC_BRANCH: begin
        dec_a = in_rs1_data;
        dec_b = in_rs2_data;
        case (funct3)
          3'b000, 3'b001: dec_ctrl = ALU_SUB;
          3'b100, 3'b101: dec_ctrl = ALU_SLT;
          3'b110, 3'b111: dec_ctrl = ALU_SLTU;
          default:        dec_illegal = 1'b1;
        endcase
      end

      OPC_LUI: begin
        dec_a = '0;
        dec_b = imm_u;
      end

      OPC_AUIPC: begin
        dec_a = in_pc;
        dec_b = imm_u;
      end

      OPC_JAL: begin
        dec_a = in_pc;
        dec_b = imm_j;
      end

      default: dec_illegal = 1'b1;
    endcase

    // Illegal entries still flow to the trap unit, but with neutral operands
    if (dec_illegal) begin
      dec_a    = '0;
      dec_b    = '0;
      dec_ctrl = ALU_ADD;
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  // Single-entry register next state: flush wins, then load, then consume
  always_comb begin
    out_valid_d = out_valid_q;
    payload_d   = payload_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d        = 1'b1;
      payload_d.alu_a    = dec_a;
      payload_d.alu_b    = dec_b;
      payload_d.alu_ctrl = dec_ctrl;
      payload_d.rs2_data = in_rs2_data;
      payload_d.pc       = in_pc;
      payload_d.funct3   = funct3;
      payload_d.illegal  = dec_illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      payload_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      payload_q   <= payload_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign alu_a        = payload_q.alu_a;
  assign alu_b        = payload_q.alu_b;
  assign alu_ctrl     = payload_q.alu_ctrl;
  assign out_rs2_data = payload_q.rs2_data;
  assign out_pc       = payload_q.pc;
  assign out_funct3   = payload_q.funct3;
  assign out_illegal  = payload_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table plus hand-written
// backpressure, flush and reset sequences.

module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] out_rs2_data;
  logic [31:0] out_pc;
  logic [2:0]  out_funct3;
  logic        out_illegal;

  int tests;
  int fails;

  alu_issue_stage #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctrl     (alu_ctrl),
    .out_rs2_data (out_rs2_data),
    .out_pc       (out_pc),
    .out_funct3   (out_funct3),
    .out_illegal  (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [3:0]  exp_ctrl;
    logic [2:0]  exp_f3;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] instr, input logic [31:0] pc,
                     input logic [31:0] rs1, input logic [31:0] rs2,
                     input logic [31:0] ea, input logic [31:0] eb,
                     input logic [3:0] ec, input logic [2:0] ef3, input logic eill);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
    v.exp_a = ea; v.exp_b = eb; v.exp_ctrl = ec; v.exp_f3 = ef3; v.exp_ill = eill;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid = 1'b1; in_instr = instr; in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2;
  endtask

  task automatic chk_reset_vals(input int idx);
    chk("rst_valid", idx, 32'(out_valid), 32'd0);
    chk("rst_a", idx, alu_a, 32'd0);
    chk("rst_b", idx, alu_b, 32'd0);
    chk("rst_ctrl", idx, 32'(alu_ctrl), 32'd0);
    chk("rst_rs2", idx, out_rs2_data, 32'd0);
    chk("rst_pc", idx, out_pc, 32'd0);
    chk("rst_f3", idx, 32'(out_funct3), 32'd0);
    chk("rst_ill", idx, 32'(out_illegal), 32'd0);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;

    //   instr         pc          rs1          rs2          exp_a        exp_b        ctrl     f3      ill
    add(32'h002081B3, 32'h0,      32'd5,       32'd7,       32'd5,       32'd7,       4'b0000, 3'b000, 1'b0); // ADD
    add(32'h402081B3, 32'h4,      32'd5,       32'd7,       32'd5,       32'd7,       4'b0001, 3'b000, 1'b0); // SUB
    add(32'h002091B3, 32'h8,      32'hA,       32'hB,       32'hA,       32'hB,       4'b1000, 3'b001, 1'b0); // SLL
    add(32'h0020A1B3, 32'hC,      32'hA,       32'hB,       32'hA,       32'hB,       4'b0101, 3'b010, 1'b0); // SLT
    add(32'h0020B1B3, 32'h10,     32'hA,       32'hB,       32'hA,       32'hB,       4'b0111, 3'b011, 1'b0); // SLTU
    add(32'h0020C1B3, 32'h14,     32'hA,       32'hB,       32'hA,       32'hB,       4'b0110, 3'b100, 1'b0); // XOR
    add(32'h0020D1B3, 32'h18,     32'hA,       32'hB,       32'hA,       32'hB,       4'b1001, 3'b101, 1'b0); // SRL
    add(32'h4020D1B3, 32'h1C,     32'hA,       32'hB,       32'hA,       32'hB,       4'b1010, 3'b101, 1'b0); // SRA
    add(32'h0020E1B3, 32'h20,     32'hA,       32'hB,       32'hA,       32'hB,       4'b0011, 3'b110, 1'b0); // OR
    add(32'h0020F1B3, 32'h24,     32'hA,       32'hB,       32'hA,       32'hB,       4'b0010, 3'b111, 1'b0); // AND
    add(32'h4020E1B3, 32'h28,     32'hA,       32'hB,       32'h0,       32'h0,       4'b0000, 3'b110, 1'b1); // OR with alt funct7
    add(32'h02208133, 32'h2C,     32'hA,       32'hB,       32'h0,       32'h0,       4'b0000, 3'b000, 1'b1); // MUL
    add(32'hFFF00093, 32'h30,     32'h0,       32'h0,       32'h0,       32'hFFFFFFFF, 4'b0000, 3'b000, 1'b0); // ADDI -1
    add(32'h40315093, 32'h34,     32'h80000000, 32'h9,      32'h80000000, 32'h3,      4'b1010, 3'b101, 1'b0); // SRAI 3
    add(32'h40010093, 32'h38,     32'h1,       32'h0,       32'h1,       32'h400,     4'b0000, 3'b000, 1'b0); // ADDI bit30
    add(32'hFFB12093, 32'h3C,     32'h1,       32'h0,       32'h1,       32'hFFFFFFFB, 4'b0101, 3'b010, 1'b0); // SLTI -5
    add(32'h01F11093, 32'h40,     32'h1,       32'h0,       32'h1,       32'h1F,      4'b1000, 3'b001, 1'b0); // SLLI 31
    add(32'h41F11093, 32'h44,     32'h1,       32'h0,       32'h0,       32'h0,       4'b0000, 3'b001, 1'b1); // SLLI bad funct7
    add(32'h7FF17093, 32'h48,     32'h1,       32'h0,       32'h1,       32'h7FF,     4'b0010, 3'b111, 1'b0); // ANDI
    add(32'hFF812283, 32'h4C,     32'h1000,    32'h0,       32'h1000,    32'hFFFFFFF8, 4'b0000, 3'b010, 1'b0); // LW -8
    add(32'h004100E7, 32'h50,     32'h2000,    32'h0,       32'h2000,    32'h4,       4'b0000, 3'b000, 1'b0); // JALR 4
    add(32'h00112423, 32'h54,     32'h3000,    32'hDEADBEEF, 32'h3000,   32'h8,       4'b0000, 3'b010, 1'b0); // SW 8
    add(32'hFE112E23, 32'h58,     32'h3000,    32'h1234,    32'h3000,    32'hFFFFFFFC, 4'b0000, 3'b010, 1'b0); // SW -4
    add(32'h00208463, 32'h5C,     32'd5,       32'd7,       32'd5,       32'd7,       4'b0001, 3'b000, 1'b0); // BEQ
    add(32'h0020C463, 32'h60,     32'd5,       32'd7,       32'd5,       32'd7,       4'b0101, 3'b100, 1'b0); // BLT
    add(32'h0020E463, 32'h64,     32'd5,       32'd7,       32'd5,       32'd7,       4'b0111, 3'b110, 1'b0); // BLTU
    add(32'h0020A463, 32'h68,     32'd5,       32'd7,       32'h0,       32'h0,       4'b0000, 3'b010, 1'b1); // branch f3=010
    add(32'h123452B7, 32'h6C,     32'h55,      32'h0,       32'h0,       32'h12345000, 4'b0000, 3'b101, 1'b0); // LUI
    add(32'h00001097, 32'h100,    32'h55,      32'h0,       32'h100,     32'h1000,    4'b0000, 3'b001, 1'b0); // AUIPC
    add(32'hFFDFF0EF, 32'h200,    32'h55,      32'h0,       32'h200,     32'hFFFFFFFC, 4'b0000, 3'b111, 1'b0); // JAL -4
    add(32'h0000000B, 32'h204,    32'h55,      32'h66,      32'h0,       32'h0,       4'b0000, 3'b000, 1'b1); // custom opcode

    step(); step();
    chk_reset_vals(0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", 0, 32'(in_ready), 32'd1);
    chk("idle_valid", 0, 32'(out_valid), 32'd0);

    // Decode table at full throughput
    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      step();
      chk("valid", i, 32'(out_valid), 32'd1);
      chk("alu_a", i, alu_a, vecs[i].exp_a);
      chk("alu_b", i, alu_b, vecs[i].exp_b);
      chk("ctrl", i, 32'(alu_ctrl), 32'(vecs[i].exp_ctrl));
      chk("funct3", i, 32'(out_funct3), 32'(vecs[i].exp_f3));
      chk("illegal", i, 32'(out_illegal), 32'(vecs[i].exp_ill));
      chk("pc", i, out_pc, vecs[i].pc);
      chk("rs2", i, out_rs2_data, vecs[i].rs2);
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", 0, 32'(out_valid), 32'd0);

    // Backpressure: A held for three cycles while B waits, then A,B,C drain in order
    out_ready = 1'b0;
    drive(32'h002081B3, 32'h1000, 32'h11, 32'h1);
    chk("bp_ready_empty", 0, 32'(in_ready), 32'd1);
    step();
    drive(32'h002081B3, 32'h1004, 32'h22, 32'h2);
    for (int c = 0; c < 3; c++) begin
      chk("bp_ready_held", c, 32'(in_ready), 32'd0);
      chk("bp_valid_held", c, 32'(out_valid), 32'd1);
      chk("bp_a_held", c, alu_a, 32'h11);
      chk("bp_pc_held", c, out_pc, 32'h1000);
      chk("bp_rs2_held", c, out_rs2_data, 32'h1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_consume", 0, 32'(in_ready), 32'd1);
    step();
    chk("bp_valid_b", 0, 32'(out_valid), 32'd1);
    chk("bp_a_b", 0, alu_a, 32'h22);
    chk("bp_pc_b", 0, out_pc, 32'h1004);
    drive(32'h002081B3, 32'h1008, 32'h33, 32'h3);
    step();
    chk("bp_valid_c", 0, 32'(out_valid), 32'd1);
    chk("bp_a_c", 0, alu_a, 32'h33);
    chk("bp_pc_c", 0, out_pc, 32'h1008);
    in_valid = 1'b0;
    step();
    chk("bp_empty", 0, 32'(out_valid), 32'd0);

    // Flush with a held entry and a same-cycle input
    out_ready = 1'b0;
    drive(32'h00F00093, 32'h2000, 32'h0, 32'h0);
    step();
    chk("fl_held", 0, 32'(out_valid), 32'd1);
    drive(32'h0AA00093, 32'h2004, 32'h0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 0, 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    step();
    chk("fl_absent", 0, 32'(out_valid), 32'd0);

    // Flush with out_ready=1 (in_ready reads 1) still drops the input
    drive(32'h0BB00093, 32'h2008, 32'h0, 32'h0);
    flush = 1'b1;
    chk("fl_ready_high", 0, 32'(in_ready), 32'd1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl2_valid", 0, 32'(out_valid), 32'd0);

    // Reset mid-stream overrides a same-cycle load
    drive(32'h00001097, 32'h300, 32'h5, 32'h77);
    step();
    chk("mr_loaded", 0, 32'(out_valid), 32'd1);
    chk("mr_a", 0, alu_a, 32'h300);
    drive(32'h0020E463, 32'h304, 32'h5, 32'h77);
    rst_n = 1'b0;
    step();
    chk_reset_vals(1);
    rst_n = 1'b1;
    in_valid = 1'b0;
    step();
    chk("mr_after", 0, 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
